run_framer: RTL and testbench

- Per-channel stream stage between one axi_read_master output channel and its MERGER_INTEGRATION input. One instance per read channel; 8 per tree.
- Slices the raw 512-bit beat stream into runs of cfg_run_beats beats.
- After each run, injects one terminator beat: all-ones data with tlast=1. The merger uses it to flush that run.
- Reports done once cfg_num_runs runs plus their terminators have left the output.

---
 rtl/merger_pkg.sv | 16 +
 rtl/axis_reg_slice.sv | 41 ++++
 rtl/run_framer.sv | 136 +++++++++++++
 tb/tb_run_framer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/merger_pkg.sv
// Shared types and constants for the merge-tree read-channel framing stage.
package merger_pkg;

    localparam int unsigned AXIS_TDATA_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        TERM = 2'd2,
        FIN  = 2'd3
    } framer_state_t;

    // Terminator beat: every record all-ones, so the merger flushes the run.
    localparam logic [AXIS_TDATA_WIDTH-1:0] TERM_WORD = '1;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream output register; outputs come straight from flops.
module axis_reg_slice #(
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_slot_free
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    // The owner only asserts i_load while o_slot_free, so a stalled beat never changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_last      = r_last;
    assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/run_framer.sv
// Slices a beat stream into runs of cfg_run_beats beats, appending an all-ones
// terminator beat (tlast=1) after each run; pulses done when the pass drains.
module run_framer
    import merger_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_SORTER_BIT_WIDTH = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          cfg_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  cfg_run_beats,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  cfg_num_runs,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          done,
    output framer_state_t                 o_dbg_state
);

    localparam int unsigned XW = C_XFER_SIZE_WIDTH;
    localparam int unsigned NUM_RECS = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
    localparam logic [C_AXIS_TDATA_WIDTH-1:0] TERM_DATA = {NUM_RECS{{C_SORTER_BIT_WIDTH{1'b1}}}};
    localparam logic [XW:0] ONE = {{XW{1'b0}}, 1'b1};

    framer_state_t r_state, w_next_state;
    logic [XW-1:0] r_beat_cnt, r_run_cnt, r_run_beats, r_num_runs;
    logic [XW-1:0] w_beat_cnt_nxt, w_run_cnt_nxt, w_run_beats_nxt, w_num_runs_nxt;
    logic          r_done, w_done_nxt;
    logic          w_load, w_load_last, w_slot_free, w_s_tready;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_load_data;
    logic [XW:0]   w_beat_inc, w_run_inc;

    // Counters stay below their latched bounds, so the extra bit only guards the compare.
    assign w_beat_inc = {1'b0, r_beat_cnt} + ONE;
    assign w_run_inc  = {1'b0, r_run_cnt} + ONE;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_run_cnt   <= '0;
            r_run_beats <= '0;
            r_num_runs  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_run_beats <= w_run_beats_nxt;
            r_num_runs  <= w_num_runs_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_run_cnt_nxt   = r_run_cnt;
        w_run_beats_nxt = r_run_beats;
        w_num_runs_nxt  = r_num_runs;
        w_done_nxt      = 1'b0;
        w_load          = 1'b0;
        w_load_last     = 1'b0;
        w_load_data     = s_axis_tdata;
        w_s_tready      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_run_beats_nxt = cfg_run_beats;
                    w_num_runs_nxt  = cfg_num_runs;
                    w_beat_cnt_nxt  = '0;
                    w_run_cnt_nxt   = '0;
                    if (cfg_num_runs == '0)       w_next_state = FIN;
                    else if (cfg_run_beats == '0) w_next_state = TERM;
                    else                          w_next_state = PASS;
                end
            end
            PASS: begin
                w_s_tready = w_slot_free;
                if (s_axis_tvalid && w_slot_free) begin
                    w_load = 1'b1;
                    if (w_beat_inc == {1'b0, r_run_beats}) begin
                        w_beat_cnt_nxt = '0;
                        w_next_state   = TERM;
                    end else begin
                        w_beat_cnt_nxt = w_beat_inc[XW-1:0];
                    end
                end
            end
            TERM: begin
                if (w_slot_free) begin
                    w_load        = 1'b1;
                    w_load_last   = 1'b1;
                    w_load_data   = TERM_DATA;
                    w_run_cnt_nxt = w_run_inc[XW-1:0];
                    if (w_run_inc == {1'b0, r_num_runs}) w_next_state = FIN;
                    else if (r_run_beats == '0)          w_next_state = TERM;
                    else                                 w_next_state = PASS;
                end
            end
            FIN: begin
                if (w_slot_free) begin
                    w_done_nxt   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    axis_reg_slice #(
        .DATA_WIDTH(C_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .clk        (aclk),
        .rst_n      (areset_n),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_last     (w_load_last),
        .i_ready    (m_axis_tready),
        .o_valid    (m_axis_tvalid),
        .o_data     (m_axis_tdata),
        .o_last     (m_axis_tlast),
        .o_slot_free(w_slot_free)
    );

    assign s_axis_tready = w_s_tready;
    assign done          = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_run_framer.sv
// Randomized scoreboard bench for run_framer: a run/terminator model fills the
// expected queue, an independent monitor pops it on every output handshake.
module tb_run_framer;
  import merger_pkg::*;

  localparam int DW = 512;
  localparam int XW = 32;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [XW-1:0] cfg_run_beats = '0;
  logic [XW-1:0] cfg_num_runs = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          done;
  framer_state_t dbg_state;

  run_framer dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .cfg_start    (cfg_start),
    .cfg_run_beats(cfg_run_beats),
    .cfg_num_runs (cfg_num_runs),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .done         (done),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int ready_pct = 100;
  bit chk_no_tready = 1'b0;

  // expected {tlast, tdata}
  logic [DW:0] exp_q[$];
  int done_seen = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- sink ready driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1 m_axis_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;

  always @(negedge aclk) begin
    if (!areset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat) begin
          n_err++;
          $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", m_axis_tvalid,
                   {m_axis_tlast, m_axis_tdata}, prev_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: got %h expected no beat", {m_axis_tlast, m_axis_tdata});
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            n_err++;
            $display("FAIL out_beat: got %h expected %h", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
        last_hs_cyc = cyc;
      end
      if (chk_no_tready) begin
        n_vec++;
        if (s_axis_tready) begin
          n_err++;
          $display("FAIL no_tready: got 1 expected 0");
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic pulse_cfg(input int rb, input int nr);
    cfg_run_beats = rb;
    cfg_num_runs  = nr;
    cfg_start     = 1'b1;
    @(posedge aclk);
    #1 cfg_start = 1'b0;
  endtask

  // Returns 1 when the beat was accepted, 0 on timeout.
  task automatic send_beat(input logic [DW-1:0] d, output bit ok);
    bit hs;
    int budget;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    budget = 0;
    do begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      budget++;
    end while (!hs && budget < 1000);
    ok = hs;
    s_axis_tvalid = 1'b0;
  endtask

  // Reference model: the stream is cut into nr runs of rb beats, each followed
  // by one all-ones terminator; done arrives one cycle after the final handshake.
  task automatic run_pass(input int rb, input int nr, input int pct, input bit busy,
                          input bit hold, input int stop_after);
    logic [DW-1:0] beats[$];
    int start_cyc;
    int timeout;
    bit ok;
    beats.delete();
    for (int i = 0; i < rb * nr; i++) beats.push_back(rand_beat());
    for (int r = 0; r < nr; r++) begin
      for (int b = 0; b < rb; b++) exp_q.push_back({1'b0, beats[r*rb + b]});
      exp_q.push_back({1'b1, TERM_WORD});
    end
    done_seen = 0;
    ready_pct = pct;
    if (hold) begin
      chk_no_tready = 1'b1;
      s_axis_tdata  = rand_beat();
      s_axis_tvalid = 1'b1;
    end
    start_cyc = cyc;
    pulse_cfg(rb, nr);
    for (int i = 0; i < rb * nr; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge aclk);
        #1;
      end
      send_beat(beats[i], ok);
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_accept: got timeout expected beat %0d accepted", i);
        break;
      end
      if (busy && i == 1) pulse_cfg(7, 5);
      if (stop_after == i + 1) return;
    end
    timeout = 0;
    while (done_seen == 0 && timeout < 2000) begin
      @(posedge aclk);
      #1;
      timeout++;
    end
    repeat (3) @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    chk_no_tready = 1'b0;
    check("done_count", done_seen, 1);
    check("exp_q_drained", exp_q.size(), 0);
    if (nr > 0) check("done_latency", done_cyc - last_hs_cyc, 1);
    else        check("done_zero_runs", (done_cyc - start_cyc) <= 2, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata_zero", m_axis_tdata == '0, 1);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, IDLE);
    areset_n = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    run_pass(4, 2, 100, 1'b0, 1'b0, -1);   // basic framing
    run_pass(4, 2, 30, 1'b0, 1'b0, -1);    // backpressure
    run_pass(0, 3, 100, 1'b0, 1'b1, -1);   // zero-length runs
    run_pass(5, 0, 100, 1'b0, 1'b1, -1);   // zero runs

    // mid-operation reset after the 2nd beat of the second run
    run_pass(4, 2, 100, 1'b0, 1'b0, 6);
    areset_n = 1'b0;
    @(posedge aclk);
    #1 areset_n = 1'b1;
    exp_q.delete();
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_no_done", done_seen, 0);
    run_pass(1, 1, 100, 1'b0, 1'b0, -1);

    run_pass(4, 2, 70, 1'b1, 1'b0, -1);    // cfg_start while busy is ignored

    for (int t = 0; t < 4; t++)
      run_pass($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(20, 100),
               1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
